id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register of the 5-stage 16-bit CPU.
- Decodes the fetched 16-bit instruction into the control word the ALU consumes: 3-bit op, 4-bit shift amount, A/B operands, and flag-write enable.
- Registers that control word for the EX stage.
- Detects load-use hazards, inserts bubbles on stall or flush, and holds a sticky halt.

Parameters:
DSIZE, 16, datapath width
RSIZE, 4, register-address width (16 registers, R0 reads zero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_i  in  16  instruction from IF/ID
instr_valid_i  in  1  instr_i holds a real instruction
flush_i  in  1  taken branch resolved in EX; kill the instruction in ID
rs_addr_o  out  4  RF read port 1 address (comb)
rt_addr_o  out  4  RF read port 2 address (comb)
rf_rdata1_i  in  16  RF data for rs_addr_o
rf_rdata2_i  in  16  RF data for rt_addr_o
stall_o  out  1  freeze PC and IF/ID (comb)
halted_o  out  1  sticky halt
ex_valid_o  out  1  EX stage holds a real instruction
ex_alu_op_o  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA, 111 RL
ex_alu_imm_o  out  4  shift amount
ex_a_o  out  16  ALU A operand
ex_b_o  out  16  ALU B operand
ex_store_data_o  out  16  SW data
ex_rd_o  out  4  destination register
ex_reg_we_o  out  1  writeback enable
ex_mem_re_o  out  1  load
ex_mem_we_o  out  1  store
ex_flag_we_o  out  1  latch ALU Flag {Z,V,N}
ex_is_br_o  out  1  conditional branch
ex_br_cond_o  out  3  branch condition code
ex_br_off_o  out  9  signed word offset
ex_illegal_o  out  1  undefined opcode

Behaviour:
- Instruction fields:
  - op = instr[15:12], rd = [11:8], rs = [7:4], rt/imm4 = [3:0].
  - 0000–0011 (R-type): alu_op = op[2:0], A = R[rs], B = R[rt], reg_we = 1, flag_we = 1.
  - 0100–0111 (shift/rotate): alu_op = op[2:0], A = R[rs], imm = imm4, B = 0, reg_we = 1, flag_we = 0.
  - 1000 LW: rd ← M[R[rs] + sext(imm4)]. alu_op = ADD, B = sext(imm4), mem_re = 1, reg_we = 1.
  - 1001 SW: M[R[rs] + sext(imm4)] ← R[rd]. rt_addr_o = rd, store_data = R[rd], mem_we = 1.
  - 1010 LLI: rd ← sext(instr[7:0]). alu_op = ADD, A = 0, B = sext(imm8), reg_we = 1.
  - 1100 BR: cond = [11:9], off = [8:0], is_br = 1, no writes.
  - 1111 HLT.
  - 1011, 1101, 1110: illegal. Behaves as a NOP with ex_illegal_o = 1 for one cycle.
- Source-register usage:
  - rs used by all except LLI, BR, HLT.
  - rt used by R-type.
  - rd used as a source by SW.
  - Register 0 never causes a hazard.
- Load-use hazard:
  - stall_o = ex_valid_o & ex_mem_re_o & ex_rd_o ≠ 0 & (ex_rd_o matches any used source of the ID instruction) & instr_valid_i & !flush_i.
  - stall_o is combinational, so it asserts in the same cycle as the hazard.
- Clock edge priority (highest first):
  1. rst: all ex_* outputs = 0, halted_o = 0. Applies asynchronously, including mid-stall.
  2. halted_o = 1: register loads a bubble. Inputs are ignored until rst.
  3. flush_i: bubble (all ex_* = 0). Flush beats stall.
  4. stall_o: bubble into EX. The ID instruction is re-presented next cycle by the frozen IF/ID.
  5. instr_valid_i = 0: bubble.
  6. Otherwise: load the decoded word with ex_valid_o = 1.
- A bubble means every ex_* output is 0. The ADD/zero-operand encoding is harmless.
- Halt:
  - halted_o sets on the edge where a HLT loads into EX (not flushed).
  - It remains set until rst.
  - stall_o = 0 while halted.
- Latency: decode-to-EX is exactly 1 cycle; a stall adds exactly 1 bubble.
- Arithmetic: sign extension to DSIZE, replicating the MSB of the field. No other arithmetic in this block.

Decomposition:
- Shared package/define file holds:
  - opcode constants (OP_ADD … OP_HLT)
  - ALU op encodings
  - branch condition codes
  - RSIZE
  - the flag bit positions Z = 2, V = 1, N = 0
- One combinational sub-module, instr_decoder (instr → control word + source-usage bits), instantiated once.
- Hazard logic and the pipeline register live in the top module.

Test Plan:
- ADD R3,R1,R2 with rdata1 = 0x0005, rdata2 = 0x0007 → next cycle: alu_op = 000, a = 5, b = 7, rd = 3, reg_we = 1, flag_we = 1, valid = 1.
- SRA R4,R5,#3 (0x6453) → alu_op = 110, imm = 3, reg_we = 1, flag_we = 0, rs_addr_o = 5.
- LW R2,[R1+#-1] (0x821F), then ADD R4,R2,R3 → stall_o = 1 for one cycle; bubble in EX (valid = 0); ADD enters on the next cycle.
- Same LW followed by ADD R4,R0,R3 with rd of LW = 0 → stall_o never asserts.
- flush_i = 1 while SW in ID and a load-use stall condition is also present → EX gets a bubble, mem_we = 0, stall_o = 0.
- HLT (0xF000), then ADD → halted_o = 1 after one cycle; every later EX slot is a bubble; assert rst mid-run → all outputs 0 immediately, before the clock edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage of the 16-bit CPU.
// Holds datapath widths, opcode constants, ALU op and branch condition
// encodings, flag bit positions, the packed EX control word and the
// sign-extension helpers.
package id_ex_stage_pkg;

  localparam int DSIZE = 16;
  localparam int RSIZE = 4;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_RL  = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LLI = 4'b1010;
  localparam logic [3:0] OP_BR  = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // ALU op encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_RL  = 3'b111;

  // Branch condition codes (instr[11:9])
  localparam logic [2:0] BR_NEQ    = 3'b000;
  localparam logic [2:0] BR_EQ     = 3'b001;
  localparam logic [2:0] BR_GT     = 3'b010;
  localparam logic [2:0] BR_LT     = 3'b011;
  localparam logic [2:0] BR_GTE    = 3'b100;
  localparam logic [2:0] BR_LTE    = 3'b101;
  localparam logic [2:0] BR_OVFL   = 3'b110;
  localparam logic [2:0] BR_UNCOND = 3'b111;

  // ALU flag register bit positions {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Control word held in the ID/EX register. All-zero is a bubble.
  typedef struct packed {
    logic             valid;
    logic [2:0]       alu_op;
    logic [3:0]       alu_imm;
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
    logic [DSIZE-1:0] store_data;
    logic [RSIZE-1:0] rd;
    logic             reg_we;
    logic             mem_re;
    logic             mem_we;
    logic             flag_we;
    logic             is_br;
    logic [2:0]       br_cond;
    logic [8:0]       br_off;
    logic             illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic [DSIZE-1:0] sext4(input logic [3:0] v);
    return {{(DSIZE-4){v[3]}}, v};
  endfunction

  function automatic logic [DSIZE-1:0] sext8(input logic [7:0] v);
    return {{(DSIZE-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/id_ex_stage_instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   i_instr     - instruction in ID
//   i_rdata1    - register file data for o_rs_addr
//   i_rdata2    - register file data for o_rt_addr
//   o_rs_addr   - RF read port 1 address (instr[7:4])
//   o_rt_addr   - RF read port 2 address (instr[3:0], or rd for SW)
//   o_ctrl      - decoded control word (packed ctrl_t), valid bit set
//   o_use_rs    - port 1 address is a real source operand
//   o_use_rt    - port 2 address is a real source operand
//   o_is_hlt    - instruction is HLT
module instr_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [15:0]       i_instr,
  input  logic [DSIZE-1:0]  i_rdata1,
  input  logic [DSIZE-1:0]  i_rdata2,
  output logic [RSIZE-1:0]  o_rs_addr,
  output logic [RSIZE-1:0]  o_rt_addr,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_use_rs,
  output logic              o_use_rt,
  output logic              o_is_hlt
);

  logic [3:0]       w_op;
  logic [RSIZE-1:0] w_rd;
  logic [RSIZE-1:0] w_rs;
  logic [3:0]       w_rt;
  ctrl_t            w_c;

  assign w_op = i_instr[15:12];
  assign w_rd = i_instr[11:8];
  assign w_rs = i_instr[7:4];
  assign w_rt = i_instr[3:0];

  assign o_rs_addr = w_rs;
  // SW reads its store data through the second port using the rd field.
  assign o_rt_addr = (w_op == OP_SW) ? w_rd : w_rt;

  always_comb begin
    w_c       = '0;
    w_c.valid = 1'b1;
    o_use_rs  = 1'b0;
    o_use_rt  = 1'b0;
    o_is_hlt  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        w_c.alu_op  = w_op[2:0];
        w_c.a       = i_rdata1;
        w_c.b       = i_rdata2;
        w_c.rd      = w_rd;
        w_c.reg_we  = 1'b1;
        w_c.flag_we = 1'b1;
        o_use_rs    = 1'b1;
        o_use_rt    = 1'b1;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_RL: begin
        w_c.alu_op  = w_op[2:0];
        w_c.a       = i_rdata1;
        w_c.alu_imm = w_rt;
        w_c.rd      = w_rd;
        w_c.reg_we  = 1'b1;
        o_use_rs    = 1'b1;
      end
      OP_LW: begin
        w_c.alu_op = ALU_ADD;
        w_c.a      = i_rdata1;
        w_c.b      = sext4(w_rt);
        w_c.rd     = w_rd;
        w_c.mem_re = 1'b1;
        w_c.reg_we = 1'b1;
        o_use_rs   = 1'b1;
      end
      OP_SW: begin
        w_c.alu_op     = ALU_ADD;
        w_c.a          = i_rdata1;
        w_c.b          = sext4(w_rt);
        w_c.store_data = i_rdata2;
        w_c.mem_we     = 1'b1;
        o_use_rs       = 1'b1;
        o_use_rt       = 1'b1;
      end
      OP_LLI: begin
        w_c.alu_op = ALU_ADD;
        w_c.b      = sext8(i_instr[7:0]);
        w_c.rd     = w_rd;
        w_c.reg_we = 1'b1;
      end
      OP_BR: begin
        w_c.is_br   = 1'b1;
        w_c.br_cond = i_instr[11:9];
        w_c.br_off  = i_instr[8:0];
      end
      OP_HLT: begin
        o_is_hlt = 1'b1;
      end
      default: begin
        // Undefined opcodes are NOPs, but still count rs as a source so
        // the hazard rule stays uniform across every non-LLI/BR/HLT opcode.
        w_c.illegal = 1'b1;
        o_use_rs    = 1'b1;
      end
    endcase
  end

  assign o_ctrl = w_c;

endmodule

// File: rtl/id_ex_stage.sv
// Instruction-decode stage plus ID/EX pipeline register.
// Decodes instr_i, registers the ALU control word for EX, detects
// load-use hazards (stall_o), inserts bubbles on flush/stall/invalid,
// and holds a sticky halt once HLT reaches EX.
// Ports:
//   clk, rst           - clock (rising edge), async active-high reset
//   instr_i, instr_valid_i, flush_i - ID instruction and control
//   rs_addr_o, rt_addr_o, rf_rdata1_i, rf_rdata2_i - RF read ports
//   stall_o            - freeze PC and IF/ID (combinational)
//   halted_o           - sticky halt
//   ex_*_o             - registered control word for EX
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_i,
  input  logic             instr_valid_i,
  input  logic             flush_i,
  output logic [RSIZE-1:0] rs_addr_o,
  output logic [RSIZE-1:0] rt_addr_o,
  input  logic [DSIZE-1:0] rf_rdata1_i,
  input  logic [DSIZE-1:0] rf_rdata2_i,
  output logic             stall_o,
  output logic             halted_o,
  output logic             ex_valid_o,
  output logic [2:0]       ex_alu_op_o,
  output logic [3:0]       ex_alu_imm_o,
  output logic [DSIZE-1:0] ex_a_o,
  output logic [DSIZE-1:0] ex_b_o,
  output logic [DSIZE-1:0] ex_store_data_o,
  output logic [RSIZE-1:0] ex_rd_o,
  output logic             ex_reg_we_o,
  output logic             ex_mem_re_o,
  output logic             ex_mem_we_o,
  output logic             ex_flag_we_o,
  output logic             ex_is_br_o,
  output logic [2:0]       ex_br_cond_o,
  output logic [8:0]       ex_br_off_o,
  output logic             ex_illegal_o
);

  logic [CTRL_W-1:0] w_dec_bits;
  ctrl_t             w_dec;
  logic              w_use_rs;
  logic              w_use_rt;
  logic              w_is_hlt;
  logic              w_src_match;
  logic              w_stall;

  ctrl_t r_ex;
  logic  r_halted;

  instr_decoder u_dec (
    .i_instr   (instr_i),
    .i_rdata1  (rf_rdata1_i),
    .i_rdata2  (rf_rdata2_i),
    .o_rs_addr (rs_addr_o),
    .o_rt_addr (rt_addr_o),
    .o_ctrl    (w_dec_bits),
    .o_use_rs  (w_use_rs),
    .o_use_rt  (w_use_rt),
    .o_is_hlt  (w_is_hlt)
  );

  assign w_dec = w_dec_bits;

  // rt_addr_o already carries rd for SW, so port-2 usage covers it.
  assign w_src_match = (w_use_rs && (rs_addr_o == r_ex.rd)) ||
                       (w_use_rt && (rt_addr_o == r_ex.rd));

  assign w_stall = !r_halted && r_ex.valid && r_ex.mem_re &&
                   (r_ex.rd != '0) && w_src_match &&
                   instr_valid_i && !flush_i;

  assign stall_o = w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex     <= '0;
      r_halted <= 1'b0;
    end else if (r_halted) begin
      r_ex <= '0;
    end else if (flush_i || w_stall || !instr_valid_i) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_dec;
      if (w_is_hlt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign halted_o        = r_halted;
  assign ex_valid_o      = r_ex.valid;
  assign ex_alu_op_o     = r_ex.alu_op;
  assign ex_alu_imm_o    = r_ex.alu_imm;
  assign ex_a_o          = r_ex.a;
  assign ex_b_o          = r_ex.b;
  assign ex_store_data_o = r_ex.store_data;
  assign ex_rd_o         = r_ex.rd;
  assign ex_reg_we_o     = r_ex.reg_we;
  assign ex_mem_re_o     = r_ex.mem_re;
  assign ex_mem_we_o     = r_ex.mem_we;
  assign ex_flag_we_o    = r_ex.flag_we;
  assign ex_is_br_o      = r_ex.is_br;
  assign ex_br_cond_o    = r_ex.br_cond;
  assign ex_br_off_o     = r_ex.br_off;
  assign ex_illegal_o    = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a driver issues one ID instruction per cycle and
// pushes the EX word a reference model predicts; a monitor pops and
// compares one word after every rising edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        halted;
    logic        valid;
    logic [2:0]  op;
    logic [3:0]  imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sd;
    logic [3:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        flag_we;
    logic        is_br;
    logic [2:0]  cond;
    logic [8:0]  off;
    logic        ill;
  } exp_t;

  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] instr;
  logic        instr_valid;
  logic        flush;
  logic [3:0]  rs_addr, rt_addr;
  logic [15:0] rdata1, rdata2;
  logic        stall, halted, ex_valid;
  logic [2:0]  ex_alu_op;
  logic [3:0]  ex_alu_imm;
  logic [15:0] ex_a, ex_b, ex_sd;
  logic [3:0]  ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we, ex_flag_we, ex_is_br, ex_ill;
  logic [2:0]  ex_br_cond;
  logic [8:0]  ex_br_off;

  logic [15:0] rf [16];
  assign rdata1 = rf[rs_addr];
  assign rdata2 = rf[rt_addr];

  id_ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .instr_i         (instr),
    .instr_valid_i   (instr_valid),
    .flush_i         (flush),
    .rs_addr_o       (rs_addr),
    .rt_addr_o       (rt_addr),
    .rf_rdata1_i     (rdata1),
    .rf_rdata2_i     (rdata2),
    .stall_o         (stall),
    .halted_o        (halted),
    .ex_valid_o      (ex_valid),
    .ex_alu_op_o     (ex_alu_op),
    .ex_alu_imm_o    (ex_alu_imm),
    .ex_a_o          (ex_a),
    .ex_b_o          (ex_b),
    .ex_store_data_o (ex_sd),
    .ex_rd_o         (ex_rd),
    .ex_reg_we_o     (ex_reg_we),
    .ex_mem_re_o     (ex_mem_re),
    .ex_mem_we_o     (ex_mem_we),
    .ex_flag_we_o    (ex_flag_we),
    .ex_is_br_o      (ex_is_br),
    .ex_br_cond_o    (ex_br_cond),
    .ex_br_off_o     (ex_br_off),
    .ex_illegal_o    (ex_ill)
  );

  logic [W-1:0] w_obs;
  assign w_obs = {halted, ex_valid, ex_alu_op, ex_alu_imm, ex_a, ex_b, ex_sd,
                  ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, ex_flag_we,
                  ex_is_br, ex_br_cond, ex_br_off, ex_ill};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  exp_t m_prev;
  logic m_halted;
  bit   rand_rf;

  function automatic logic [15:0] s4(input logic [3:0] v);
    return (v >= 4'd8) ? (16'(v) - 16'd16) : 16'(v);
  endfunction

  function automatic logic [15:0] s8(input logic [7:0] v);
    return (v >= 8'd128) ? (16'(v) - 16'd256) : 16'(v);
  endfunction

  function automatic bit uses_reg(input logic [15:0] ins, input logic [3:0] r);
    int op = int'(ins[15:12]);
    bit u = 0;
    if (!(op == 10 || op == 12 || op == 15) && ins[7:4] == r) u = 1;
    if (op <= 3 && ins[3:0] == r) u = 1;
    if (op == 9 && ins[11:8] == r) u = 1;
    return u;
  endfunction

  function automatic exp_t model_decode(input logic [15:0] ins);
    exp_t e = '0;
    int op = int'(ins[15:12]);
    logic [3:0] rd = ins[11:8];
    logic [3:0] rs = ins[7:4];
    logic [3:0] lo = ins[3:0];
    e.valid = 1'b1;
    if (op <= 3) begin
      e.op = 3'(op); e.a = rf[rs]; e.b = rf[lo]; e.rd = rd;
      e.reg_we = 1'b1; e.flag_we = 1'b1;
    end else if (op <= 7) begin
      e.op = 3'(op); e.a = rf[rs]; e.imm = lo; e.rd = rd; e.reg_we = 1'b1;
    end else if (op == 8) begin
      e.a = rf[rs]; e.b = s4(lo); e.rd = rd; e.mem_re = 1'b1; e.reg_we = 1'b1;
    end else if (op == 9) begin
      e.a = rf[rs]; e.b = s4(lo); e.sd = rf[rd]; e.mem_we = 1'b1;
    end else if (op == 10) begin
      e.b = s8(ins[7:0]); e.rd = rd; e.reg_we = 1'b1;
    end else if (op == 12) begin
      e.is_br = 1'b1; e.cond = ins[11:9]; e.off = ins[8:0];
    end else if (op != 15) begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic bit model_stall(input logic [15:0] ins, input logic v,
                                     input logic f);
    return !m_halted && v && !f && m_prev.valid && m_prev.mem_re &&
           (m_prev.rd != 4'd0) && uses_reg(ins, m_prev.rd);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [15:0] ins, input logic v, input logic f,
                       output bit stalled);
    exp_t e;
    bit   es;
    @(negedge clk);
    if (rand_rf) begin
      for (int i = 1; i < 16; i++) rf[i] = 16'($urandom);
    end
    instr = ins; instr_valid = v; flush = f;
    #1;
    es = model_stall(ins, v, f);
    check("stall", 128'(stall), 128'(es));
    check("rs_addr", 128'(rs_addr), 128'(ins[7:4]));
    check("rt_addr", 128'(rt_addr), 128'((ins[15:12] == 4'd9) ? ins[11:8] : ins[3:0]));
    e = '0;
    if (!m_halted && v && !f && !es) begin
      e = model_decode(ins);
      if (ins[15:12] == 4'hF) m_halted = 1'b1;
    end
    e.halted = m_halted;
    exp_q.push_back(e);
    m_prev = e;
    stalled = es;
  endtask

  // Issue an instruction, re-presenting it while the model says stall.
  task automatic issue(input logic [15:0] ins, input logic f);
    bit s;
    drive(ins, 1'b1, f, s);
    while (s) drive(ins, 1'b1, 1'b0, s);
  endtask

  // Assert reset mid-cycle with ins in ID; outputs must clear before any edge.
  task automatic reset_mid(input logic [15:0] ins, input bit expect_stall);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1; flush = 1'b0;
    #1;
    if (expect_stall) check("pre_rst_stall", 128'(stall), 128'(model_stall(ins, 1'b1, 1'b0)));
    #2;
    rst = 1'b1;
    #1;
    check("rst_ex_word", 128'(w_obs), 128'(0));
    check("rst_stall", 128'(stall), 128'(0));
    m_prev = '0; m_halted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op = 4'($urandom_range(0, 14));
    if (op == 4'd10 || op == 4'd12)
      return {op, 4'($urandom_range(0, 3)), 8'($urandom)};
    return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("ex_word", 128'(w_obs), 128'(exp_w));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit s;
    logic [15:0] ins;
    logic v, f;
    rf[0] = 16'h0000;
    for (int i = 1; i < 16; i++) rf[i] = 16'(i) * 16'h0101;
    rf[1] = 16'h0005;
    rf[2] = 16'h0007;
    rand_rf = 0;
    m_prev = '0; m_halted = 1'b0;
    instr = 16'h0; instr_valid = 1'b0; flush = 1'b0;
    #1;
    check("reset_ex_word", 128'(w_obs), 128'(0));
    check("reset_stall", 128'(stall), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    issue(16'h0312, 1'b0);          // ADD R3,R1,R2 -> a=5 b=7
    issue(16'h6453, 1'b0);          // SRA R4,R5,#3
    issue(16'h821F, 1'b0);          // LW R2,[R1-1]
    issue(16'h0423, 1'b0);          // ADD R4,R2,R3 : one stall
    issue(16'h801F, 1'b0);          // LW R0,[R1-1]
    issue(16'h0403, 1'b0);          // ADD R4,R0,R3 : no stall
    issue(16'h821F, 1'b0);          // LW R2
    drive(16'h9212, 1'b1, 1'b1, s); // SW R2 with flush : bubble, no stall
    issue(16'h831F, 1'b0);          // LW R3
    issue(16'h9310, 1'b0);          // SW R3,[R1] : rd source stall
    issue(16'hA580, 1'b0);          // LLI R5,#-128
    issue(16'hC1FF, 1'b0);          // BR
    issue(16'hB123, 1'b0);          // illegal
    drive(16'h0312, 1'b0, 1'b0, s); // invalid slot

    // Randomized traffic (no HLT)
    rand_rf = 1;
    s = 0; ins = 16'h0; v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s) begin
        ins = rand_instr();
        v = ($urandom_range(0, 9) != 0);
      end
      f = ($urandom_range(0, 9) == 0);
      drive(ins, v, f, s);
    end

    // Flushed HLT must not halt, then real HLT followed by more traffic
    drive(16'hF000, 1'b1, 1'b1, s);
    issue(16'hF000, 1'b0);
    issue(16'h0312, 1'b0);
    for (int i = 0; i < 5; i++) drive(rand_instr(), 1'b1, 1'b0, s);
    reset_mid(16'h0312, 1'b0);

    // Reset asserted while a load-use stall is present
    issue(16'h821F, 1'b0);
    reset_mid(16'h0423, 1'b1);

    s = 0;
    for (int i = 0; i < 60; i++) begin
      if (!s) begin
        ins = rand_instr();
        v = ($urandom_range(0, 9) != 0);
      end
      f = ($urandom_range(0, 9) == 0);
      drive(ins, v, f, s);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
